// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants, widths and controller state type
package sha256_pkg;

   localparam int WORD   = 32;
   localparam int BLOCK  = 512;
   localparam int DIGEST = 256;

   localparam logic [DIGEST-1:0] H_0 =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_e;

   localparam logic [WORD-1:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

endpackage

// File: rtl/sha256_Krom.sv
// rtl/sha256_Krom.sv - round-constant ROM with registered read
module sha256_Krom
   import sha256_pkg::*;
(
   input  logic        clk_i,
   input  logic [5:0]  addr_i,
   output logic [31:0] k_o
);
   logic [31:0] k_q;

   always_ff @(posedge clk_i) begin
      k_q <= K_TAB[addr_i];
   end

   assign k_o = k_q;
endmodule

// File: rtl/sha256_msg_sched.sv
// rtl/sha256_msg_sched.sv - 16-word sliding message-schedule window
module sha256_msg_sched
   import sha256_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [BLOCK-1:0] blk_data_i,
   output logic [WORD-1:0]  w_o
);
   logic [WORD-1:0] w_q [16];
   logic [WORD-1:0] s0_w1, s1_w14, w_new;

   sha256_s0 u_s0 (.x_i(w_q[1]),  .y_o(s0_w1));
   sha256_s1 u_s1 (.x_i(w_q[14]), .y_o(s1_w14));

   // Word 16 relative to the current window head, consumed 16 rounds later.
   assign w_new = s1_w14 + w_q[9] + s0_w1 + w_q[0];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
      end else if (load_i) begin
         for (int i = 0; i < 16; i++) w_q[i] <= blk_data_i[BLOCK-1-WORD*i -: WORD];
      end else if (shift_i) begin
         for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
         w_q[15] <= w_new;
      end
   end

   assign w_o = w_q[0];
endmodule

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round on {a..h}
module sha256_round (
   input  logic [255:0] state_i,
   input  logic [31:0]  k_i,
   input  logic [31:0]  w_i,
   output logic [255:0] state_o
);
   logic [31:0] a, b, c, d, e, f, g, h;
   logic [31:0] big_s0, big_s1, ch, maj, t1, t2;

   assign {a, b, c, d, e, f, g, h} = state_i;

   assign big_s0 = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
   assign big_s1 = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
   assign ch     = (e & f) ^ (~e & g);
   assign maj    = (a & b) ^ (a & c) ^ (b & c);
   assign t1     = h + big_s1 + ch + k_i + w_i;
   assign t2     = big_s0 + maj;

   assign state_o = {t1 + t2, a, b, c, d + t1, e, f, g};
endmodule

// File: rtl/sha256_s0.sv
// rtl/sha256_s0.sv - message-schedule small sigma0
module sha256_s0 (
   input  logic [31:0] x_i,
   output logic [31:0] y_o
);
   assign y_o = {x_i[6:0], x_i[31:7]} ^ {x_i[17:0], x_i[31:18]} ^ (x_i >> 3);
endmodule

// File: rtl/sha256_s1.sv
// rtl/sha256_s1.sv - message-schedule small sigma1
module sha256_s1 (
   input  logic [31:0] x_i,
   output logic [31:0] y_o
);
   assign y_o = {x_i[16:0], x_i[31:17]} ^ {x_i[18:0], x_i[31:19]} ^ (x_i >> 10);
endmodule

// File: rtl/sha256_block_ctrl.sv
// rtl/sha256_block_ctrl.sv - sequences 64 rounds per block over one round unit, owns chaining H
module sha256_block_ctrl
   import sha256_pkg::*;
#(
   parameter int ROUNDS   = 64,
   parameter bit CHAIN_EN = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              blk_valid_i,
   output logic              blk_ready_o,
   input  logic [BLOCK-1:0]  blk_data_i,
   input  logic              blk_first_i,
   output logic              digest_valid_o,
   input  logic              digest_ready_i,
   output logic [DIGEST-1:0] digest_o,
   output logic              busy_o
);
   localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

   state_e            state_q, state_d;
   logic [DIGEST-1:0] h_q, h_d, work_q, work_d, round_out, init_h;
   logic [RW-1:0]     rnd_q, rnd_d;
   logic [5:0]        kaddr_q, kaddr_d;
   logic              seeded_q, seeded_d;
   logic              sched_load, sched_shift, fresh;
   logic [WORD-1:0]   k_word, w_word;

   assign fresh  = blk_first_i || !CHAIN_EN;
   assign init_h = fresh ? H_0 : h_q;

   sha256_Krom u_krom (
      .clk_i  (clk_i),
      .addr_i (kaddr_q),
      .k_o    (k_word)
   );

   sha256_msg_sched u_sched (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .load_i     (sched_load),
      .shift_i    (sched_shift),
      .blk_data_i (blk_data_i),
      .w_o        (w_word)
   );

   sha256_round u_round (
      .state_i (work_q),
      .k_i     (k_word),
      .w_i     (w_word),
      .state_o (round_out)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         h_q      <= '0;
         work_q   <= '0;
         rnd_q    <= '0;
         kaddr_q  <= '0;
         seeded_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         work_q   <= work_d;
         rnd_q    <= rnd_d;
         kaddr_q  <= kaddr_d;
         seeded_q <= seeded_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      h_d            = h_q;
      work_d         = work_q;
      rnd_d          = rnd_q;
      kaddr_d        = kaddr_q;
      seeded_d       = seeded_q;
      sched_load     = 1'b0;
      sched_shift    = 1'b0;
      blk_ready_o    = 1'b0;
      digest_valid_o = 1'b0;
      busy_o         = 1'b0;
      case (state_q)
         IDLE: begin
            blk_ready_o = 1'b1;
            if (blk_valid_i) begin
               h_d        = init_h;
               work_d     = init_h;
               kaddr_d    = '0;
               sched_load = 1'b1;
               seeded_d   = seeded_q | fresh;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            // ROM read of K[0] happens here so round 0 sees it on the next cycle.
            busy_o  = 1'b1;
            kaddr_d = 6'd1;
            rnd_d   = '0;
            state_d = ROUND;
         end
         ROUND: begin
            busy_o      = 1'b1;
            work_d      = round_out;
            sched_shift = 1'b1;
            kaddr_d     = kaddr_q + 6'd1;
            rnd_d       = rnd_q + RW'(1);
            if (rnd_q == RW'(ROUNDS - 1)) begin
               for (int i = 0; i < 8; i++)
                  h_d[WORD*i +: WORD] = h_q[WORD*i +: WORD] + round_out[WORD*i +: WORD];
               state_d = DONE;
            end
         end
         DONE: begin
            digest_valid_o = 1'b1;
            if (digest_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign digest_o = h_q;

   // A chained block before any first block since reset continues from H=0.
   chain_from_reset: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      (state_q == IDLE && blk_valid_i && !fresh) |-> seeded_q)
      else $warning("block chained from reset value H=0");

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// tb/tb_sha256_block_ctrl.sv - randomized scoreboard bench for sha256_block_ctrl
module tb_sha256_block_ctrl;

   localparam logic [511:0] ABC_BLK   = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, {15{32'h0}}};
   localparam logic [511:0] TWO_B1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] TWO_B2    = {{15{32'h0}}, 32'h000001c0};
   localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         blk_valid = 1'b0;
   logic         blk_ready;
   logic [511:0] blk_data = '0;
   logic         blk_first = 1'b0;
   logic         digest_valid;
   logic         digest_ready = 1'b1;
   logic [255:0] digest;
   logic         busy;

   always #5 clk = ~clk;

   sha256_block_ctrl dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .blk_valid_i    (blk_valid),
      .blk_ready_o    (blk_ready),
      .blk_data_i     (blk_data),
      .blk_first_i    (blk_first),
      .digest_valid_o (digest_valid),
      .digest_ready_i (digest_ready),
      .digest_o       (digest),
      .busy_o         (busy)
   );

   typedef struct {
      logic [255:0] dig;
      int           acc;
   } exp_t;

   exp_t         exp_q[$];
   int           n_vec = 0;
   int           n_bad = 0;
   int           cyc = 0;
   int           hs_edge = -1;
   int           last_acc = 0;
   logic [31:0]  k_tb [64];
   logic [255:0] h0_tb;
   logic [255:0] model_h = '0;
   bit           rand_dr = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] frac32(input real r);
      real f;
      f = r - $floor(r);
      return 32'(longint'($floor(f * 4294967296.0)));
   endfunction

   // Textbook compression: full 64-word schedule, then 64 rounds, then feed-forward.
   function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0]  w [64];
      logic [31:0]  v [8];
      logic [31:0]  t1, t2;
      logic [255:0] res;
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_tb[t] + w[t];
         t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
         v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
      return res;
   endfunction

   task automatic send(input logic [511:0] d, input logic first, input bit use_kat, input logic [255:0] kat);
      int   guard;
      exp_t e;
      logic [255:0] hin;
      guard = 0;
      @(negedge clk);
      blk_valid = 1'b1;
      blk_data  = d;
      blk_first = first;
      while (!blk_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (!blk_ready) begin
         fail("accept_timeout");
         blk_valid = 1'b0;
         return;
      end
      hin     = first ? h0_tb : model_h;
      model_h = compress(hin, d);
      e.dig   = use_kat ? kat : model_h;
      e.acc   = cyc + 1;
      last_acc = cyc + 1;
      exp_q.push_back(e);
      @(posedge clk);
      #1 blk_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0) fail("drain_timeout");
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_blk_ready"}, 256'(blk_ready), 256'(1));
      check({tag, "_busy"}, 256'(busy), 256'(0));
      check({tag, "_digest_valid"}, 256'(digest_valid), 256'(0));
      check({tag, "_digest"}, digest, 256'(0));
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      logic prev_dv;
      logic [255:0] prev_dig;
      if (!rst_n) begin
         prev_dv = 1'b0;
      end else begin
         if (digest_valid && prev_dv !== 1'b1) begin
            if (exp_q.size() == 0) fail("unexpected_digest_valid");
            else check("latency", 256'(cyc - exp_q[0].acc), 256'(65));
         end
         if (digest_valid && prev_dv === 1'b1) check("digest_stable", digest, prev_dig);
         if (digest_valid) begin
            check("blk_ready_in_done", 256'(blk_ready), 256'(0));
            check("busy_in_done", 256'(busy), 256'(0));
         end
         if (digest_valid && digest_ready) begin
            if (exp_q.size() == 0) begin
               fail("unexpected_digest");
            end else begin
               e = exp_q.pop_front();
               check("digest", digest, e.dig);
            end
            hs_edge = cyc + 1;
         end
         prev_dv  = digest_valid;
         prev_dig = digest;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int p, cnt, guard;
      bit isp;
      logic [511:0] blk;
      p = 1;
      cnt = 0;
      while (cnt < 64) begin
         p++;
         isp = 1'b1;
         for (int d = 2; d * d <= p; d++) if (p % d == 0) isp = 1'b0;
         if (isp) begin
            k_tb[cnt] = frac32($pow(real'(p), 1.0 / 3.0));
            if (cnt < 8) h0_tb[255-32*cnt -: 32] = frac32($sqrt(real'(p)));
            cnt++;
         end
      end

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      send(ABC_BLK, 1'b1, 1'b1, ABC_DIG);
      send(EMPTY_BLK, 1'b1, 1'b1, EMPTY_DIG);
      send(TWO_B1, 1'b1, 1'b0, '0);
      send(TWO_B2, 1'b0, 1'b1, TWO_DIG);
      send(ABC_BLK, 1'b1, 1'b1, ABC_DIG);
      drain();

      // Backpressure: hold the digest 10 cycles while the next block waits.
      digest_ready = 1'b0;
      send(ABC_BLK, 1'b1, 1'b1, ABC_DIG);
      guard = 0;
      while (!digest_valid && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!digest_valid) fail("digest_valid_timeout");
      fork
         begin
            repeat (10) @(posedge clk);
            #1 digest_ready = 1'b1;
         end
         send(EMPTY_BLK, 1'b1, 1'b1, EMPTY_DIG);
      join
      check("accept_after_handshake", 256'(last_acc - hs_edge), 256'(1));
      drain();

      // Asynchronous reset in the middle of round t=30.
      send(ABC_BLK, 1'b1, 1'b1, ABC_DIG);
      while (cyc < last_acc + 31) @(negedge clk);
      check("busy_in_round", 256'(busy), 256'(1));
      rst_n = 1'b0;
      exp_q.delete();
      model_h = '0;
      #1;
      check_reset_outputs("midround_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(ABC_BLK, 1'b1, 1'b1, ABC_DIG);
      drain();

      rand_dr = 1'b1;
      fork
         begin
            for (int n = 0; n < 14; n++) begin
               for (int w = 0; w < 16; w++) blk[511-32*w -: 32] = $urandom();
               send(blk, (n == 0) || ($urandom_range(0, 2) == 0), 1'b0, '0);
            end
            drain();
            rand_dr = 1'b0;
         end
         begin
            while (rand_dr) begin
               @(posedge clk);
               #1 digest_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      digest_ready = 1'b1;
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
